// File: rtl/reset_run_sequencer.sv
// Staggered multi-domain reset release with sticky done capture, optional run timeout,
// restart without external reset, and a saturating run-cycle counter.
module reset_run_sequencer #(
    parameter int unsigned RST_CYCLES = 4,
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned STAGE_GAP  = 2,
    parameter int unsigned TIMEOUT    = 0,
    parameter int unsigned CNT_W      = 24
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_restart,
    input  logic [NUM_CH-1:0] in_done,
    output logic [NUM_CH-1:0] out_reset,
    output logic [NUM_CH-1:0] out_run,
    output logic              out_finish,
    output logic              out_timeout,
    output logic [CNT_W-1:0]  out_cycles
);

    localparam int unsigned HoldW = $clog2(RST_CYCLES + 1);
    localparam int unsigned GapW  = $clog2(STAGE_GAP + 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(RST_CYCLES);
    localparam logic [GapW-1:0]  GapLast  = GapW'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] CntMax   = '1;

    typedef enum logic [2:0] {StHold, StStagger, StRun, StFinish, StTimeout} state_e;

    state_e             state_q, state_d;
    logic [HoldW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [GapW-1:0]    gap_cnt_q, gap_cnt_d;
    logic [NUM_CH-1:0]  done_q, done_d;
    logic [NUM_CH-1:0]  out_reset_q, out_reset_d;
    logic [NUM_CH-1:0]  out_run_q, out_run_d;
    logic               out_finish_q, out_finish_d;
    logic               out_timeout_q, out_timeout_d;
    logic [CNT_W-1:0]   out_cycles_q, out_cycles_d;

    logic [NUM_CH-1:0]  done_cap;
    logic [NUM_CH-1:0]  reset_next;
    logic               all_done;
    logic               timed_out;
    logic               active;

    // Done is only trusted from domains already out of reset.
    assign done_cap   = done_q | (in_done & ~out_reset_q);
    assign all_done   = &done_cap;
    // Clearing the lowest set bit releases domains in index order.
    assign reset_next = out_reset_q & (out_reset_q - NUM_CH'(1));
    assign timed_out  = (TIMEOUT != 0) && (64'(out_cycles_q) >= 64'(TIMEOUT));
    assign active     = (state_q == StStagger) || (state_q == StRun);

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        done_d        = done_cap;
        out_reset_d   = out_reset_q;
        out_finish_d  = out_finish_q;
        out_timeout_d = out_timeout_q;
        out_cycles_d  = out_cycles_q;

        unique case (state_q)
            StHold: begin
                if (hold_cnt_q == HoldLast) begin
                    out_reset_d = reset_next;
                    gap_cnt_d   = '0;
                    state_d     = (reset_next == '0) ? StRun : StStagger;
                end else begin
                    hold_cnt_d = hold_cnt_q + HoldW'(1);
                end
            end
            StStagger: begin
                if (gap_cnt_q == GapLast) begin
                    out_reset_d = reset_next;
                    gap_cnt_d   = '0;
                    if (reset_next == '0) begin
                        state_d = StRun;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GapW'(1);
                end
            end
            StRun: begin
            end
            StFinish, StTimeout: begin
                if (in_restart) begin
                    state_d       = StHold;
                    // The restart edge itself counts as the first hold cycle.
                    hold_cnt_d    = HoldW'(1);
                    gap_cnt_d     = '0;
                    done_d        = '0;
                    out_reset_d   = '1;
                    out_finish_d  = 1'b0;
                    out_timeout_d = 1'b0;
                    out_cycles_d  = '0;
                end
            end
            default: begin
                state_d = StHold;
            end
        endcase

        if (active) begin
            if (out_cycles_q != CntMax) begin
                out_cycles_d = out_cycles_q + CNT_W'(1);
            end
            if (all_done) begin
                state_d      = StFinish;
                out_reset_d  = out_reset_q;
                out_finish_d = 1'b1;
            end else if (timed_out) begin
                state_d       = StTimeout;
                out_reset_d   = '1;
                out_finish_d  = 1'b1;
                out_timeout_d = 1'b1;
            end
        end

        out_run_d = ((state_d == StFinish) || (state_d == StTimeout)) ? '0 : ~out_reset_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StHold;
            hold_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            done_q        <= '0;
            out_reset_q   <= '1;
            out_run_q     <= '0;
            out_finish_q  <= 1'b0;
            out_timeout_q <= 1'b0;
            out_cycles_q  <= '0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            done_q        <= done_d;
            out_reset_q   <= out_reset_d;
            out_run_q     <= out_run_d;
            out_finish_q  <= out_finish_d;
            out_timeout_q <= out_timeout_d;
            out_cycles_q  <= out_cycles_d;
        end
    end

    assign out_reset   = out_reset_q;
    assign out_run     = out_run_q;
    assign out_finish  = out_finish_q;
    assign out_timeout = out_timeout_q;
    assign out_cycles  = out_cycles_q;

endmodule

// File: tb/tb_reset_run_sequencer.sv
// Bench for reset_run_sequencer: a timing model fills a scoreboard each cycle, plus
// spot checks on release, finish, timeout, restart and counter saturation.
module tb_reset_run_sequencer;

    localparam int RstCycles = 4;
    localparam int GapA = 3;
    localparam int TmoA = 20;
    localparam int CmaxA = 32'h00FF_FFFF;
    localparam int GapB = 2;
    localparam int TmoB = 0;
    localparam int CmaxB = 15;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_restart;
    logic [1:0]  in_done_a, in_done_b;
    logic [1:0]  out_reset_a, out_run_a, out_reset_b, out_run_b;
    logic        out_finish_a, out_timeout_a, out_finish_b, out_timeout_b;
    logic [23:0] out_cycles_a;
    logic [3:0]  out_cycles_b;

    always #5 clock = ~clock;

    reset_run_sequencer #(
        .RST_CYCLES(RstCycles), .NUM_CH(2), .STAGE_GAP(GapA), .TIMEOUT(TmoA), .CNT_W(24)
    ) dut_a (
        .clock(clock), .reset(reset), .in_restart(in_restart), .in_done(in_done_a),
        .out_reset(out_reset_a), .out_run(out_run_a), .out_finish(out_finish_a),
        .out_timeout(out_timeout_a), .out_cycles(out_cycles_a)
    );

    reset_run_sequencer #(
        .RST_CYCLES(RstCycles), .NUM_CH(2), .STAGE_GAP(GapB), .TIMEOUT(TmoB), .CNT_W(4)
    ) dut_b (
        .clock(clock), .reset(reset), .in_restart(in_restart), .in_done(in_done_b),
        .out_reset(out_reset_b), .out_run(out_run_b), .out_finish(out_finish_b),
        .out_timeout(out_timeout_b), .out_cycles(out_cycles_b)
    );

    // phase: 0 hold, 1 sequencing/run, 2 finished, 3 timed out
    typedef struct {
        int         phase;
        int         release_at;
        int         rel0;
        logic [1:0] done;
        int         cyc;
    } model_t;

    typedef struct {
        int         inst;
        logic [1:0] rst;
        logic [1:0] run;
        logic       fin;
        logic       tmo;
        int         cyc;
    } exp_t;

    exp_t   sb_q[$];
    model_t m_a, m_b;
    int     edge_n, checks, errors;
    int     t0, r, t_r10, t_r00, t_fin, t_to, t_c20;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic model_t model_step(model_t m, int n, logic rst, logic rs,
                                          logic [1:0] dn, int gap, int tmo, int cmax);
        model_t     res;
        logic [1:0] rel_before;
        logic [1:0] nd;
        int         old;
        res = m;
        if (rst) begin
            res.phase = 0; res.release_at = n + 1 + RstCycles;
            res.done = 2'b00; res.cyc = 0; res.rel0 = 0;
        end else begin
            case (m.phase)
                0: if (n == m.release_at) begin
                    res.phase = 1; res.rel0 = n; res.cyc = 0;
                end
                1: begin
                    for (int k = 0; k < 2; k++) rel_before[k] = ((n - 1) >= (m.rel0 + gap * k));
                    nd = m.done | (dn & rel_before);
                    old = m.cyc;
                    res.cyc = (old + 1 > cmax) ? cmax : old + 1;
                    res.done = nd;
                    if (nd == 2'b11) res.phase = 2;
                    else if (tmo != 0 && old >= tmo) res.phase = 3;
                end
                default: if (rs) begin
                    res.phase = 0; res.release_at = n + RstCycles;
                    res.done = 2'b00; res.cyc = 0;
                end
            endcase
        end
        return res;
    endfunction

    function automatic exp_t model_out(model_t m, int n, int gap, int inst);
        exp_t e;
        e.inst = inst; e.fin = 1'b0; e.tmo = 1'b0; e.cyc = m.cyc;
        e.rst = 2'b11; e.run = 2'b00;
        case (m.phase)
            1: begin
                for (int k = 0; k < 2; k++) e.rst[k] = !(n >= (m.rel0 + gap * k));
                e.run = ~e.rst;
            end
            2: begin e.rst = 2'b00; e.fin = 1'b1; end
            3: begin e.fin = 1'b1; e.tmo = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic clear_marks();
        t_r10 = -1; t_r00 = -1; t_fin = -1; t_to = -1; t_c20 = -1;
    endtask

    task automatic tick();
        int   n;
        exp_t e;
        n = edge_n + 1;
        m_a = model_step(m_a, n, reset, in_restart, in_done_a, GapA, TmoA, CmaxA);
        sb_q.push_back(model_out(m_a, n, GapA, 0));
        m_b = model_step(m_b, n, reset, in_restart, in_done_b, GapB, TmoB, CmaxB);
        sb_q.push_back(model_out(m_b, n, GapB, 1));
        @(posedge clock);
        edge_n = n;
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.inst == 0) begin
                check_eq("a_reset", 32'(out_reset_a), 32'(e.rst));
                check_eq("a_run", 32'(out_run_a), 32'(e.run));
                check_eq("a_finish", 32'(out_finish_a), 32'(e.fin));
                check_eq("a_timeout", 32'(out_timeout_a), 32'(e.tmo));
                check_eq("a_cycles", 32'(out_cycles_a), e.cyc);
            end else begin
                check_eq("b_reset", 32'(out_reset_b), 32'(e.rst));
                check_eq("b_run", 32'(out_run_b), 32'(e.run));
                check_eq("b_finish", 32'(out_finish_b), 32'(e.fin));
                check_eq("b_timeout", 32'(out_timeout_b), 32'(e.tmo));
                check_eq("b_cycles", 32'(out_cycles_b), e.cyc);
            end
        end
        if (out_reset_a == 2'b10 && t_r10 < 0) t_r10 = n;
        if (out_reset_a == 2'b00 && t_r00 < 0) t_r00 = n;
        if (out_finish_a && t_fin < 0) t_fin = n;
        if (out_timeout_a && t_to < 0) t_to = n;
        if (out_cycles_a == 24'd20 && t_c20 < 0) t_c20 = n;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_restart = 1'b0; in_done_a = 2'b11; in_done_b = 2'b00;
        checks = 0; errors = 0; edge_n = 0;
        m_a = '{0, 1 << 30, 0, 2'b00, 0};
        m_b = '{0, 1 << 30, 0, 2'b00, 0};
        clear_marks();

        // Reset values and staggered release with stale done held from reset.
        repeat (2) tick();
        check_eq("reset_val_rst", 32'(out_reset_a), 32'd3);
        check_eq("reset_val_run", 32'(out_run_a), 32'd0);
        reset = 1'b0;
        t0 = edge_n + 1;
        for (int i = 0; i < 30 && !out_finish_a; i++) tick();
        check_eq("rel0_edge", t_r10 - t0, 4);
        check_eq("rel1_edge", t_r00 - t0, 7);
        check_eq("fin_edge", t_fin - t0, 8);
        check_eq("fin_cycles", 32'(out_cycles_a), 32'd4);

        // Restart from finish.
        in_done_a = 2'b00;
        tick();
        clear_marks();
        in_restart = 1'b1;
        r = edge_n + 1;
        tick();
        in_restart = 1'b0;
        check_eq("restart_fin", 32'(out_finish_a), 32'd0);
        check_eq("restart_rst", 32'(out_reset_a), 32'd3);
        for (int i = 0; i < 20 && t_r10 < 0; i++) tick();
        check_eq("restart_rel0", t_r10 - r, 4);

        // Restart during run is ignored.
        repeat (8) tick();
        in_restart = 1'b1;
        tick();
        in_restart = 1'b0;
        check_eq("run_restart_fin", 32'(out_finish_a), 32'd0);
        check_eq("run_restart_rst", 32'(out_reset_a), 32'd0);

        // Timeout with no done.
        for (int i = 0; i < 60 && !out_timeout_a; i++) tick();
        check_eq("to_edge", t_to - t_c20, 1);
        check_eq("to_rst", 32'(out_reset_a), 32'd3);
        check_eq("to_run", 32'(out_run_a), 32'd0);
        check_eq("to_fin", 32'(out_finish_a), 32'd1);

        // Last done arrives on the timeout edge: done wins.
        in_restart = 1'b1;
        tick();
        in_restart = 1'b0;
        in_done_a = 2'b01;
        for (int i = 0; i < 60 && out_cycles_a != 24'd20; i++) tick();
        in_done_a = 2'b11;
        tick();
        check_eq("late_done_fin", 32'(out_finish_a), 32'd1);
        check_eq("late_done_to", 32'(out_timeout_a), 32'd0);
        check_eq("late_done_cyc", 32'(out_cycles_a), 32'd21);

        // Reset while only domain 0 is released, then replay.
        in_restart = 1'b1;
        tick();
        in_restart = 1'b0;
        in_done_a = 2'b00;
        for (int i = 0; i < 20 && out_reset_a != 2'b10; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mid_rst", 32'(out_reset_a), 32'd3);
        check_eq("mid_run", 32'(out_run_a), 32'd0);
        check_eq("mid_cyc", 32'(out_cycles_a), 32'd0);
        clear_marks();
        t0 = edge_n + 1;
        for (int i = 0; i < 30 && t_r00 < 0; i++) tick();
        check_eq("replay_rel0", t_r10 - t0, 4);
        check_eq("replay_rel1", t_r00 - t0, 7);

        // Saturation on the 4-bit counter.
        repeat (30) tick();
        check_eq("sat_b", 32'(out_cycles_b), 32'd15);
        repeat (5) tick();
        check_eq("sat_hold_b", 32'(out_cycles_b), 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
